// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences single-byte CPU requests onto the shared 8-bit
// ROM/RAM bus as setup / access (with wait states) / hold.
module mem_ctrl #(
    parameter int unsigned wait_states = 1,
    parameter bit          action      = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        rom_ram,
    output logic [14:0] address_bus,
    output logic        wr_en,
    output logic        rd_en,
    inout  wire  [7:0]  data_bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    state_t     state;
    logic       write_q;
    logic       block_q;
    logic [7:0] wdata_q;
    logic [3:0] wait_cnt;
    logic       accept;
    logic       blocked;
    logic       bus_oe;

    assign accept  = req_valid && req_ready;
    assign blocked = !action && req_write && !req_addr[15];

    // Only a live (non-blocked) write owns the bus, from SETUP through HOLD.
    assign bus_oe   = write_q && !block_q && (state != IDLE);
    assign data_bus = bus_oe ? wdata_q : 8'hzz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            rom_ram     <= 1'b0;
            address_bus <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            write_q     <= 1'b0;
            block_q     <= 1'b0;
            wdata_q     <= '0;
            wait_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        write_q   <= req_write;
                        wdata_q   <= req_wdata;
                        block_q   <= blocked;
                        if (blocked) begin
                            state     <= HOLD;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state       <= SETUP;
                            rom_ram     <= req_addr[15];
                            address_bus <= req_addr[14:0];
                        end
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    wait_cnt <= 4'(wait_states);
                    wr_en    <= write_q;
                    rd_en    <= !write_q;
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= HOLD;
                        wr_en     <= 1'b0;
                        rd_en     <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (!write_q) begin
                            rsp_rdata <= data_bus;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench driving three mem_ctrl instances
// (ws=1/act=1, ws=0/act=0, ws=2/act=1), each with its own ROM/RAM model.
`timescale 1ns/1ps
module tb_mem_ctrl;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       req_valid = '0;
    logic [N-1:0]       req_write = '0;
    logic [N-1:0][15:0] req_addr = '0;
    logic [N-1:0][7:0]  req_wdata = '0;

    wire [N-1:0]        req_ready;
    wire [N-1:0]        rsp_valid;
    wire [N-1:0]        rsp_err;
    wire [N-1:0]        rom_ram;
    wire [N-1:0]        wr_en;
    wire [N-1:0]        rd_en;
    wire [N-1:0][7:0]   rsp_rdata;
    wire [N-1:0][14:0]  address_bus;
    wire [N-1:0][7:0]   bus_v;

    for (genvar g = 0; g < N; g++) begin : gi
        localparam int WS  = (g == 0) ? 1 : (g == 1) ? 0 : 2;
        localparam bit ACT = (g != 1);

        tri1 [7:0]  bus;
        logic [7:0] mem [65536];

        mem_ctrl #(
            .wait_states(WS),
            .action     (ACT)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g]),
            .rom_ram    (rom_ram[g]),
            .address_bus(address_bus[g]),
            .wr_en      (wr_en[g]),
            .rd_en      (rd_en[g]),
            .data_bus   (bus)
        );

        assign bus = rd_en[g] ? mem[{rom_ram[g], address_bus[g]}] : 8'hzz;
        assign bus_v[g] = bus;

        initial begin
            for (int k = 0; k < 65536; k++) mem[k] = 8'h00;
            mem[16'h0005] = 8'h66;
            mem[16'h0040] = 8'h3C;
            mem[16'h8010] = 8'h21;
            mem[16'h8011] = 8'h42;
            mem[16'h0012] = 8'h84;
        end

        always @(posedge clk) begin
            if (wr_en[g]) mem[{rom_ram[g], address_bus[g]}] = bus;
        end
    end

    typedef struct packed {
        logic [1:0]  inst;
        logic        chk_data;
        logic [7:0]  rdata;
        logic        err;
        logic [31:0] due;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          wr_cnt [N];
    int          rd_cnt [N];
    logic [N-1:0] no_drive = '0;
    logic [15:0] exp_addr = '0;
    logic [7:0]  exp_wd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Response monitor plus per-cycle bus protocol checks.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < N; i++) begin
            check($sformatf("en_excl%0d", i), {31'd0, wr_en[i] & rd_en[i]}, 0);
            if (req_ready[i]) check($sformatf("idle_bus%0d", i), bus_v[i], 8'hFF);
            if (no_drive[i] && !rd_en[i])
                check($sformatf("no_drive%0d", i), bus_v[i], 8'hFF);
            if (wr_en[i] || rd_en[i])
                check($sformatf("en_addr%0d", i), {rom_ram[i], address_bus[i]}, exp_addr);
            if (wr_en[i]) begin
                check($sformatf("wr_data%0d", i), bus_v[i], exp_wd);
                wr_cnt[i]++;
            end
            if (rd_en[i]) rd_cnt[i]++;
            if (rsp_valid[i]) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("rsp_unexpected%0d", i), {31'd0, rsp_valid[i]}, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_inst", i, e.inst);
                    check("rsp_cycle", cyc, e.due);
                    check("rsp_err", rsp_err[i], e.err);
                    if (e.chk_data) check("rsp_rdata", rsp_rdata[i], e.rdata);
                end
            end
        end
    end

    task automatic issue(input int i, input logic wr, input logic [15:0] a,
                         input logic [7:0] wd, input logic [7:0] rd,
                         input logic err, input int lat, input bit push,
                         input bit keep);
        int t = 0;
        exp_t e;
        req_write[i] = wr;
        req_addr[i]  = a;
        req_wdata[i] = wd;
        req_valid[i] = 1'b1;
        @(negedge clk);
        while (!req_ready[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", req_ready[i], 1);
        if (!req_ready[i]) begin
            req_valid[i] = 1'b0;
            return;
        end
        last_acc = cyc;
        if (push) begin
            e.inst     = 2'(i);
            e.chk_data = !wr;
            e.rdata    = rd;
            e.err      = err;
            e.due      = 32'(cyc + lat);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        exp_addr = a;
        exp_wd   = wd;
        if (!keep) req_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int t = 0;
        while ((sb_q.size() != 0 || !req_ready[i]) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a1, a2, a3;
        for (int i = 0; i < N; i++) begin
            wr_cnt[i] = 0;
            rd_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_ready", req_ready[i], 1);
            check("rst_en", {wr_en[i], rd_en[i]}, 0);
            check("rst_rsp", {rsp_valid[i], rsp_err[i]}, 0);
            check("rst_rdata", rsp_rdata[i], 0);
            check("rst_addr", {rom_ram[i], address_bus[i]}, 0);
            check("rst_bus", bus_v[i], 8'hFF);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAM write then read, ws=1
        issue(0, 1'b1, 16'h8123, 8'hA5, 8'h00, 1'b0, 4, 1'b1, 1'b0);
        drain(0);
        check("ram_wr_cycles", wr_cnt[0], 2);
        check("ram_mem", gi[0].mem[16'h8123], 8'hA5);
        issue(0, 1'b0, 16'h8123, 8'h00, 8'hA5, 1'b0, 4, 1'b1, 1'b0);
        drain(0);
        check("ram_rd_cycles", rd_cnt[0], 2);

        // ROM read, ws=0, bus never driven by controller
        no_drive[1] = 1'b1;
        issue(1, 1'b0, 16'h0040, 8'h00, 8'h3C, 1'b0, 3, 1'b1, 1'b0);
        drain(1);
        check("rom_rd_cycles", rd_cnt[1], 1);

        // Blocked ROM writes back to back, action=0
        issue(1, 1'b1, 16'h0005, 8'h11, 8'h00, 1'b1, 1, 1'b1, 1'b1);
        a1 = last_acc;
        issue(1, 1'b1, 16'h0006, 8'h12, 8'h00, 1'b1, 1, 1'b1, 1'b0);
        a2 = last_acc;
        drain(1);
        no_drive[1] = 1'b0;
        check("blk_interval", a2 - a1, 2);
        check("blk_wr_cycles", wr_cnt[1], 0);
        check("blk_rom", gi[1].mem[16'h0005], 8'h66);
        check("blk_addr_kept", {rom_ram[1], address_bus[1]}, 16'h0040);

        // ROM write allowed, action=1
        wr_cnt[0] = 0;
        issue(0, 1'b1, 16'h0005, 8'h11, 8'h00, 1'b0, 4, 1'b1, 1'b0);
        drain(0);
        check("rom_wr_cycles", wr_cnt[0], 2);
        check("rom_mem", gi[0].mem[16'h0005], 8'h11);

        // Back-to-back reads with req_valid held, ws=2
        no_drive[2] = 1'b1;
        issue(2, 1'b0, 16'h8010, 8'h00, 8'h21, 1'b0, 5, 1'b1, 1'b1);
        a1 = last_acc;
        issue(2, 1'b0, 16'h8011, 8'h00, 8'h42, 1'b0, 5, 1'b1, 1'b1);
        a2 = last_acc;
        issue(2, 1'b0, 16'h0012, 8'h00, 8'h84, 1'b0, 5, 1'b1, 1'b0);
        a3 = last_acc;
        drain(2);
        no_drive[2] = 1'b0;
        check("b2b_gap1", a2 - a1, 6);
        check("b2b_gap2", a3 - a2, 6);
        check("b2b_rd_cycles", rd_cnt[2], 9);

        // Reset during the second ACCESS cycle of a write
        issue(0, 1'b1, 16'h8200, 8'h77, 8'h00, 1'b0, 4, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_en", {wr_en[0], rd_en[0]}, 0);
        check("mid_rst_bus", bus_v[0], 8'hFF);
        check("mid_rst_addr", {rom_ram[0], address_bus[0]}, 0);
        check("mid_rst_rsp", rsp_valid[0], 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", req_ready[0], 1);
        @(posedge clk);
        #1;
        issue(0, 1'b0, 16'h8123, 8'h00, 8'hA5, 1'b0, 4, 1'b1, 1'b0);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that initiates every access on the shared 8-bit memory bus. It accepts single-byte read/write requests from the CPU side through a valid/ready handshake. It sequences `rom_ram`, `address_bus`, `wr_en`, `rd_en` and `data_bus` toward the 32K ROM and 32K RAM responders, and returns read data and completion on a one-cycle response strobe.

## Interface

**Parameters**
- `wait_states`, default 1: extra `ACCESS` cycles beyond the first. Legal range 0..15.
- `action`, default 1: 1 = simulation, where writes to ROM are issued on the bus; 0 = synthesis, where ROM writes are blocked and flagged.

**Ports**
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: controller can accept a request. High only in `IDLE`.
- `req_write`, input, 1: 1 = write, 0 = read.
- `req_addr`, input, 16: byte address. Bit 15 selects the memory: 0 = ROM, 1 = RAM.
- `req_wdata`, input, 8: write data.
- `rsp_valid`, output, 1: one-cycle completion pulse for reads and writes.
- `rsp_rdata`, output, 8: read data. Valid while `rsp_valid` is high; holds its value afterwards.
- `rsp_err`, output, 1: pulses together with `rsp_valid` when a ROM write is blocked.
- `rom_ram`, output, 1: 0 enables ROM, 1 enables RAM. Registered copy of `req_addr[15]`.
- `address_bus`, output, 15: registered copy of `req_addr[14:0]`.
- `wr_en`, output, 1: write enable to the responders.
- `rd_en`, output, 1: read enable to the responders.
- `data_bus`, inout, 8: shared bidirectional data bus. Driven by this block only during write transactions; high-impedance otherwise.

## Operation

- **Accept.** A request is accepted on a rising edge where `req_valid && req_ready`. At that edge the controller latches `req_write`, `req_addr` and `req_wdata`. Requests are never queued; `req_ready` is low in every state except `IDLE`.
- **States.** `IDLE` → `SETUP` → `ACCESS` → `HOLD` → `IDLE`. A blocked ROM write takes the path `IDLE` → `HOLD` → `IDLE` instead.
- **`IDLE`**
  - `wr_en` = `rd_en` = 0.
  - `data_bus` is released.
  - `address_bus` and `rom_ram` keep their last values.
- **`SETUP`** (1 cycle)
  - `address_bus` and `rom_ram` show the new address.
  - Both enables are 0.
  - For a write, `data_bus` is driven with the latched data.
- **`ACCESS`** (`wait_states`+1 cycles)
  - The wait counter loads `wait_states` on entry and decrements each cycle. The controller leaves `ACCESS` when the counter reads 0.
  - For a read, `rd_en` is 1; for a write, `wr_en` is 1. The two enables are never 1 in the same cycle.
  - For a read, `data_bus` is sampled into `rsp_rdata` at the edge that ends the last `ACCESS` cycle.
- **`HOLD`** (1 cycle)
  - Both enables are 0.
  - Address and `rom_ram` are unchanged.
  - For a write, `data_bus` is still driven (hold time).
  - `rsp_valid` = 1.
- **Blocked ROM write** (`action`=0, write with `req_addr[15]`=0)
  - No enable is asserted and the bus is never driven.
  - The controller goes straight to `HOLD`, where `rsp_valid` = 1 and `rsp_err` = 1.
  - `address_bus` and `rom_ram` do not update.
- **Bus turnaround.** `data_bus` is released in every state except `SETUP`/`ACCESS`/`HOLD` of a non-blocked write. This guarantees at least one released cycle (`IDLE`) between back-to-back transactions.
- **Reset.** While `rst_n`=0 at an edge, the following take effect at that edge regardless of the current state; an in-flight transaction is abandoned with no response:
  - state returns to `IDLE`;
  - `wr_en` = `rd_en` = `rom_ram` = 0 and `address_bus` = 0;
  - `rsp_valid` = `rsp_err` = 0 and `rsp_rdata` = 0x00;
  - `data_bus` is released.
- **Request during reset.** `req_valid` is ignored while `rst_n` is low. `req_ready` is 1 on the first cycle after reset is released.

## Timing

- **Normal transaction.** With the accept edge as E0:
  - `SETUP` occupies E0–E1;
  - `ACCESS` occupies E1 to E(2+`wait_states`);
  - `HOLD` and `rsp_valid` are in the cycle after that;
  - `IDLE` follows, with `req_ready`=1.
- **Latency and throughput.** Request-to-`rsp_valid` latency is `wait_states`+3 cycles. The issue interval is `wait_states`+4 cycles.
- **Blocked ROM write.** `rsp_valid` comes 1 cycle after accept; the issue interval is 2 cycles.
- **Registered outputs.** All outputs are registered except the `data_bus` tristate enable, which decodes the state register directly. None of them produce glitches.
- **Holding `req_valid`.** If `req_valid` stays high through the `HOLD` cycle, the request is not accepted until `IDLE`. A request held high in `IDLE` is accepted on the first edge.

## Test plan

- **RAM write/read, `wait_states`=1.** Write 0xA5 to 0x8123, then read 0x8123.
  - `wr_en` is high exactly 2 cycles with `data_bus`=0xA5, `rom_ram`=1, `address_bus`=0x0123.
  - The read returns `rsp_rdata`=0xA5 with `rsp_valid` 4 cycles after accept.
- **ROM read, `wait_states`=0.** Preload ROM[0x0040]=0x3C and read 0x0040.
  - `rom_ram`=0 and `rd_en` is high for 1 cycle.
  - `rsp_rdata`=0x3C with `rsp_valid` 3 cycles after accept.
  - `data_bus` is never driven by the controller.
- **ROM write, `action`=0.** Write 0x11 to 0x0005.
  - `rsp_valid` and `rsp_err` pulse 1 cycle after accept.
  - `wr_en` stays 0 and ROM[0x0005] is unchanged.
- **ROM write, `action`=1.** Write 0x11 to 0x0005.
  - `wr_en` asserts and ROM[0x0005] becomes 0x11.
  - `rsp_err` is 0.
- **Back-to-back requests, `wait_states`=2.** Hold `req_valid` high continuously for 3 reads.
  - Accepts are exactly 6 cycles apart.
  - `rd_en` and `wr_en` are never both high.
  - `data_bus` is released between transactions.
- **Reset mid-operation.** Assert `rst_n`=0 during the second `ACCESS` cycle of a write.
  - At the next edge: enables are 0, `data_bus` is z, `address_bus`=0, no `rsp_valid`.
  - After release, `req_ready`=1 and a new read completes normally.
